cpu_trace_buffer: RTL and testbench
===================================

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 8, width of accumulator and register-value fields.
REQ-002 Parameter OP_W, default 4, width of opcode and immediate fields.
REQ-003 Parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-004 Parameter TS_W, default 16, timestamp width; ENTRY_W = TS_W+2*OP_W+2*DATA_W.
REQ-005 CLK  in  1  sole clock, all state updates on rising edge.
REQ-006 CLB  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  capture enable.
REQ-008 mode  in  1  0 = stop when full, 1 = wrap (overwrite oldest).
REQ-009 trig_en  in  1  1 = wait for trigger opcode before capturing.
REQ-010 trig_op  in  OP_W  trigger opcode.
REQ-011 clr  in  1  synchronous flush.
REQ-012 sample_valid  in  1  capture qualifier for current cycle.
REQ-013 opcode, imm  in  OP_W each  current opcode / immediate.
REQ-014 acc, reg_val  in  DATA_W each  current accumulator / register value.
REQ-015 rd_ready  in  1  consumer accepts rd_data.
REQ-016 rd_valid  out  1  oldest entry available.
REQ-017 rd_data  out  ENTRY_W  {ts, opcode, imm, acc, reg_val}, MSB first.
REQ-018 count  out  clog2(DEPTH+1)  stored entries.
REQ-019 full, empty, overflow, triggered  out  1 each  status flags.
REQ-020 state  out  2  FSM state code.

Function
REQ-021 Timestamp counter SHALL increment every cycle, wrap modulo 2^TS_W; value at write edge is stored.
REQ-022 FSM states SHALL be IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
REQ-023 IDLE: en=1 -> ARMED if trig_en=1, else CAPTURE.
REQ-024 ARMED: sample_valid=1 and opcode==trig_op -> CAPTURE, triggering sample written that same edge, triggered set.
REQ-025 CAPTURE: write one entry per edge with sample_valid=1; en=0 -> STOPPED (no write that edge).
REQ-026 STOPPED: en=0 -> IDLE; triggered cleared on entering IDLE.
REQ-027 Write latency: sample at edge N SHALL be visible on rd_data/rd_valid after edge N (one cycle).
REQ-028 Read is show-ahead: rd_valid = !empty; pop on rd_valid && rd_ready.
REQ-029 Write and pop same edge, not full: count unchanged, both pointers advance.
REQ-030 Write while empty with rd_ready=1: no pop, count becomes 1.
REQ-031 Full, mode=0, write attempt, no pop: sample dropped, overflow set, FSM -> STOPPED.
REQ-032 Full, mode=1, write, no pop: oldest overwritten, read pointer advances, count stays DEPTH, overflow set.
REQ-033 Full, any mode, write and pop same edge: no overflow, count stays DEPTH.
REQ-034 Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-035 overflow sticky until clr or reset.
REQ-036 clr=1: pointers, count, overflow, triggered -> 0, FSM -> IDLE; no write or pop that edge; clr beats all other inputs.
REQ-037 Parameter changes SHALL not alter state encoding or field order.

Reset
REQ-038 CLB=1 SHALL immediately force: state=IDLE, pointers=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, triggered=0, timestamp=0.
REQ-039 Reset mid-capture discards all stored entries; first post-reset edge SHALL see timestamp 0 (incrementing to 1 on that edge).
REQ-040 rd_data is don't-care while rd_valid=0.

Verification (DEPTH=4, DATA_W=8, OP_W=4, TS_W=16)
REQ-041 Reset, en=1, trig_en=0, four samples acc=0x11..0x44 -> count=4, full=1, pops return acc 0x11,0x22,0x33,0x44 in order, timestamps consecutive.
REQ-042 mode=0, fifth sample acc=0x55 while full -> dropped, overflow=1, state=3, first pop still acc=0x11.
REQ-043 mode=1, samples 0x11..0x66 -> count=4, pops return 0x33,0x44,0x55,0x66, overflow=1.
REQ-044 trig_en=1, trig_op=4'b1010, opcodes 0001,0011,1010,0110 -> only last two captured, triggered=1, first entry opcode=1010.
REQ-045 Full, mode=0, rd_ready=1 with simultaneous write -> overflow stays 0, count=4, newest entry present.
REQ-046 Two entries stored, assert CLB mid-cycle -> empty=1, count=0, state=0 before next edge; clr=1 in CAPTURE -> same result at next edge.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// CPU trace buffer: captures {timestamp, opcode, imm, acc, reg_val} samples
// into a circular store with show-ahead read, optional trigger arming and
// stop-when-full / wrap (overwrite oldest) policies.
//
// Ports
//   CLK, CLB      clock (rising edge) and asynchronous active-high reset
//   en            capture enable
//   mode          0 = stop when full, 1 = wrap and overwrite oldest
//   trig_en       wait for trig_op before capturing
//   trig_op       trigger opcode
//   clr           synchronous flush, dominates every other input
//   sample_valid  current cycle carries a sample
//   opcode, imm   current opcode / immediate
//   acc, reg_val  current accumulator / register value
//   rd_ready      consumer accepts rd_data
//   rd_valid      oldest entry available on rd_data
//   rd_data       {ts, opcode, imm, acc, reg_val}, MSB first
//   count         number of stored entries
//   full, empty, overflow, triggered  status flags
//   state         FSM state code (IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3)
module cpu_trace_buffer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TS_W    = 16,
  localparam int unsigned ENTRY_W = TS_W + 2 * OP_W + 2 * DATA_W,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               CLB,
  input  logic               en,
  input  logic               mode,
  input  logic               trig_en,
  input  logic [OP_W-1:0]    trig_op,
  input  logic               clr,
  input  logic               sample_valid,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    imm,
  input  logic [DATA_W-1:0]  acc,
  input  logic [DATA_W-1:0]  reg_val,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               triggered,
  output logic [1:0]         state
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOPPED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [TS_W-1:0]    ts_q;
  logic               overflow_q, triggered_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic trig_hit, wr_req, pop, drop, overwrite;
  logic do_write, rd_adv, cnt_inc, cnt_dec, ovf_set, trig_set;

  // Status decoded from the registered occupancy count
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign rd_valid  = !empty;
  assign rd_data   = mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;
  assign state     = state_q;

  // Write attempt / pop qualification shared by next-state and datapath
  assign trig_hit  = sample_valid && (opcode == trig_op);
  assign wr_req    = !clr && (((state_q == CAPTURE) && en && sample_valid) ||
                              ((state_q == ARMED) && trig_hit));
  assign pop       = !clr && rd_valid && rd_ready;
  // Full with no simultaneous pop: either drop (mode 0) or overwrite (mode 1)
  assign drop      = wr_req && full && !pop && !mode;
  assign overwrite = wr_req && full && !pop && mode;

  // State register
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = trig_en ? ARMED : CAPTURE;
        ARMED: begin
          if (trig_hit)  state_d = drop ? STOPPED : CAPTURE;
          else if (!en)  state_d = IDLE;
        end
        CAPTURE: if (!en || drop) state_d = STOPPED;
        STOPPED: if (!en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath controls derived from state and handshake
  always_comb begin
    do_write = wr_req && !drop;
    rd_adv   = pop || overwrite;
    cnt_inc  = do_write && !pop && !full;
    cnt_dec  = pop && !do_write;
    ovf_set  = wr_req && full && !pop;
    trig_set = !clr && (state_q == ARMED) && trig_hit;
  end

  // Pointers, occupancy, flags and free-running timestamp
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      ts_q        <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (clr) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        overflow_q  <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (rd_adv)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (cnt_inc)      count_q <= count_q + CNT_W'(1);
        else if (cnt_dec) count_q <= count_q - CNT_W'(1);
        if (ovf_set) overflow_q <= 1'b1;
        // Entering IDLE always drops the trigger flag
        if (state_d == IDLE) triggered_q <= 1'b0;
        else if (trig_set)   triggered_q <= 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr_q] <= {ts_q, opcode, imm, acc, reg_val};
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=4, DATA_W=8, OP_W=4, TS_W=16).
module tb_cpu_trace_buffer;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned ENTRY_W = TS_W + 2 * OP_W + 2 * DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               CLK = 1'b0;
  logic               CLB;
  logic               en, mode, trig_en, clr, sample_valid, rd_ready;
  logic [OP_W-1:0]    trig_op, opcode, imm;
  logic [DATA_W-1:0]  acc, reg_val;
  logic               rd_valid, full, empty, overflow, triggered;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;
  logic [1:0]         state;

  cpu_trace_buffer #(
    .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .CLK(CLK), .CLB(CLB), .en(en), .mode(mode), .trig_en(trig_en),
    .trig_op(trig_op), .clr(clr), .sample_valid(sample_valid),
    .opcode(opcode), .imm(imm), .acc(acc), .reg_val(reg_val),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .triggered(triggered), .state(state)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp: free-running cycle count since reset
  logic [TS_W-1:0] ts_m;
  always @(posedge CLK or posedge CLB) begin
    if (CLB) ts_m <= '0;
    else     ts_m <= ts_m + TS_W'(1);
  end

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] exp_q[$];

  typedef struct {
    bit         rst, clr, en, mode, trig_en, sv, rd;
    logic [3:0] op;
    logic [7:0] acc;
    int         cap;     // 0 none, 1 appended, 2 appended over the oldest
    int         ecount;
    bit         eovf, etrig;
    int         estate;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit cl, bit e, bit md, bit te, bit sv,
                              bit rd, logic [3:0] op, logic [7:0] a, int cap,
                              int ec, bit eo, bit et, int es);
    vec_t v;
    v.rst = rst; v.clr = cl; v.en = e; v.mode = md; v.trig_en = te;
    v.sv = sv; v.rd = rd; v.op = op; v.acc = a; v.cap = cap;
    v.ecount = ec; v.eovf = eo; v.etrig = et; v.estate = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    en = 0; mode = 0; trig_en = 0; clr = 0; sample_valid = 0; rd_ready = 0;
    opcode = '0; imm = '0; acc = '0; reg_val = '0;
  endtask

  // Called just after a rising edge; reset pulse ends well before the next edge
  task automatic do_reset();
    drive_idle();
    CLB = 1'b1;
    #3;
    CLB = 1'b0;
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input int i, input vec_t v);
    if (v.rst) do_reset();
    en = v.en; mode = v.mode; trig_en = v.trig_en; clr = v.clr;
    sample_valid = v.sv; rd_ready = v.rd; opcode = v.op;
    imm = v.op ^ 4'hF; acc = v.acc; reg_val = ~v.acc;
    #1;
    if (v.rd) begin
      chk($sformatf("v%0d.rd_valid", i), 64'(rd_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk($sformatf("v%0d.rd_data", i), 64'(rd_data), 64'(exp_q[0]));
    end
    if (v.clr) begin
      exp_q.delete();
    end else begin
      if (v.rd && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v.cap == 2) void'(exp_q.pop_front());
      if (v.cap != 0) exp_q.push_back({ts_m, v.op, imm, acc, reg_val});
    end
    step();
    chk($sformatf("v%0d.count", i),     64'(count),     64'(v.ecount));
    chk($sformatf("v%0d.full", i),      64'(full),      64'(v.ecount == DEPTH));
    chk($sformatf("v%0d.empty", i),     64'(empty),     64'(v.ecount == 0));
    chk($sformatf("v%0d.overflow", i),  64'(overflow),  64'(v.eovf));
    chk($sformatf("v%0d.triggered", i), 64'(triggered), 64'(v.etrig));
    chk($sformatf("v%0d.state", i),     64'(state),     64'(v.estate));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    trig_op = 4'b1010;
    drive_idle();
    CLB = 1'b1;
    step();
    do_reset();

    // Reset values
    chk("rst.state", 64'(state), 64'(0));
    chk("rst.count", 64'(count), 64'(0));
    chk("rst.empty", 64'(empty), 64'(1));
    chk("rst.full", 64'(full), 64'(0));
    chk("rst.rd_valid", 64'(rd_valid), 64'(0));
    chk("rst.overflow", 64'(overflow), 64'(0));
    chk("rst.triggered", 64'(triggered), 64'(0));

    //         rst clr en md te sv rd op     acc    cap cnt ovf trg st
    // Stop-when-full: four samples, fifth dropped, drain in order
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h1, 8'h00, 0, 0, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h1, 8'h11, 1, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h1, 8'h22, 1, 2, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h1, 8'h33, 1, 3, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h1, 8'h44, 1, 4, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h1, 8'h55, 0, 4, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4'h1, 8'h00, 0, 3, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4'h1, 8'h00, 0, 2, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4'h1, 8'h00, 0, 1, 1, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h1, 8'h00, 0, 0, 1, 0, 0));
    // Wrap mode: six samples keep the newest four
    vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 4'h1, 8'h00, 0, 0, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h11, 1, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h22, 1, 2, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h33, 1, 3, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h44, 1, 4, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h55, 2, 4, 1, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h1, 8'h66, 2, 4, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4'h1, 8'h00, 0, 4, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 4'h1, 8'h00, 0, 3, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 4'h1, 8'h00, 0, 2, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 4'h1, 8'h00, 0, 1, 1, 0, 3));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 4'h1, 8'h00, 0, 0, 1, 0, 3));
    // Trigger on opcode 1010: earlier opcodes ignored
    vt.push_back(mk(1, 0, 1, 0, 1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4'h1, 8'h01, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4'h3, 8'h02, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4'hA, 8'h03, 1, 1, 0, 1, 2));
    vt.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4'h6, 8'h04, 1, 2, 0, 1, 2));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h0, 8'h00, 0, 2, 0, 1, 3));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h0, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h0, 8'h00, 0, 0, 0, 0, 0));
    // Full, stop mode, write with simultaneous pop: no overflow
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h2, 8'h00, 0, 0, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h2, 8'h11, 1, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h2, 8'h22, 1, 2, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h2, 8'h33, 1, 3, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h2, 8'h44, 1, 4, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 1, 4'h2, 8'h77, 1, 4, 0, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h2, 8'h00, 0, 4, 0, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 8'h00, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 8'h00, 0, 2, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 8'h00, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h2, 8'h00, 0, 0, 0, 0, 0));
    // Write while empty with rd_ready, then write+pop not full
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h5, 8'h00, 0, 0, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 1, 4'h5, 8'h21, 1, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 1, 1, 4'h5, 8'h22, 1, 1, 0, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4'h5, 8'h00, 0, 0, 0, 0, 2));
    // clr in CAPTURE with overflow and trigger set beats everything
    vt.push_back(mk(1, 0, 1, 1, 1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 4'hA, 8'h31, 1, 1, 0, 1, 2));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 4'h1, 8'h32, 1, 2, 0, 1, 2));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 4'h1, 8'h33, 1, 3, 0, 1, 2));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 4'h1, 8'h34, 1, 4, 0, 1, 2));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 4'h1, 8'h35, 2, 4, 1, 1, 2));
    vt.push_back(mk(0, 1, 1, 1, 1, 1, 1, 4'hA, 8'h36, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));

    foreach (vt[i]) apply(i, vt[i]);

    // Asynchronous reset mid-cycle with two entries stored
    do_reset();
    en = 1;
    step();
    sample_valid = 1; opcode = 4'h7; imm = 4'h0; acc = 8'hA1; reg_val = 8'h00;
    step();
    acc = 8'hA2;
    step();
    sample_valid = 0;
    chk("async.pre_count", 64'(count), 64'(2));
    #2;
    CLB = 1'b1;
    #1;
    chk("async.state", 64'(state), 64'(0));
    chk("async.count", 64'(count), 64'(0));
    chk("async.empty", 64'(empty), 64'(1));
    chk("async.full", 64'(full), 64'(0));
    chk("async.rd_valid", 64'(rd_valid), 64'(0));
    #1;
    CLB = 1'b0;
    exp_q.delete();
    // First edge after reset moves to CAPTURE with timestamp 0 -> 1
    step();
    chk("post.state", 64'(state), 64'(2));
    sample_valid = 1; opcode = 4'h3; imm = 4'hC; acc = 8'hB1; reg_val = 8'h4E;
    step();
    sample_valid = 0; en = 0;
    chk("post.rd_valid", 64'(rd_valid), 64'(1));
    chk("post.ts", 64'(rd_data[ENTRY_W-1 -: TS_W]), 64'(1));
    chk("post.entry", 64'(rd_data), 64'({16'h0001, 4'h3, 4'hC, 8'hB1, 8'h4E}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
